// File: rtl/linear_pkg.sv
// Shared constants and types for the KWS linear-layer sequencer.
// Q8.24 sample format, default layer dimensions and the sequencer FSM encoding.
package linear_pkg;

    localparam int FRAC_BITS = 24;
    localparam int INT_BITS  = 7;
    localparam int DATA_W    = 1 + INT_BITS + FRAC_BITS;

    localparam int DEF_IN_DIM  = 20;
    localparam int DEF_OUT_DIM = 20;
    localparam int DEF_RD_LAT  = 1;
    localparam int DEF_MAC_LAT = 1;

    localparam logic SRC_CMVN = 1'b0;
    localparam logic SRC_RELU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_EMIT  = 3'd3,
        ST_DONE  = 3'd4
    } lin_state_e;

    // Ceil-log2 that never returns zero, so single-entry counters still get one bit.
    function automatic int clog2_min1(input int v);
        int w;
        w = $clog2(v);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/linear_rr_arb.sv
// Two-requester round-robin arbiter (CMVN vs ReLU) for the linear layer.
// Combinational pick; last_grant register moves only on the update strobe.
module linear_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic cmvn_req,
    input  logic relu_req,
    input  logic upd,
    input  logic upd_src,
    output logic pick_vld,
    output logic pick_src
);
    import linear_pkg::*;

    logic last_grant_q;

    // Reset points last_grant at ReLU so CMVN wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= SRC_RELU;
        end else if (upd) begin
            last_grant_q <= upd_src;
        end
    end

    always_comb begin
        pick_vld = cmvn_req | relu_req;
        if (cmvn_req && relu_req) begin
            pick_src = ~last_grant_q;
        end else begin
            pick_src = relu_req ? SRC_RELU : SRC_CMVN;
        end
    end

endmodule

// File: rtl/linear_sched.sv
// Sequencer for the 20x20 linear MAC: arbitrates a frame, issues row reads, strobes the MAC, emits rows.
// Row latency IN_DIM+RD_LAT+MAC_LAT+1 cycles; res_valid/res_addr hold and no reads issue while res_ready is low.
module linear_sched
    import linear_pkg::*;
#(
    parameter int IN_DIM  = DEF_IN_DIM,
    parameter int OUT_DIM = DEF_OUT_DIM,
    parameter int RD_LAT  = DEF_RD_LAT,
    parameter int MAC_LAT = DEF_MAC_LAT,
    localparam int IAW = clog2_min1(IN_DIM),
    localparam int WAW = clog2_min1(IN_DIM * OUT_DIM),
    localparam int OAW = clog2_min1(OUT_DIM)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmvn_req,
    input  logic           relu_req,
    output logic           cmvn_grant,
    output logic           relu_grant,
    output logic           src_sel,
    output logic           in_rd_en,
    output logic [IAW-1:0] in_rd_addr,
    output logic [WAW-1:0] w_rd_addr,
    output logic           mac_clr,
    output logic           mac_en,
    output logic           mac_last,
    output logic           res_valid,
    output logic [OAW-1:0] res_addr,
    input  logic           res_ready,
    output logic           busy,
    output logic           done
);

    localparam int DW = clog2_min1(MAC_LAT + 1);
    localparam logic [IAW-1:0] I_LAST = IAW'(IN_DIM - 1);
    localparam logic [OAW-1:0] O_LAST = OAW'(OUT_DIM - 1);
    localparam logic [DW-1:0]  D_LAST = DW'(MAC_LAT);

    lin_state_e     state_q;
    logic [IAW-1:0] i_q;
    logic [OAW-1:0] o_q;
    logic [WAW-1:0] w_q;
    logic [DW-1:0]  drain_q;
    logic           in_rd_en_q;
    logic           res_valid_q;
    logic           done_q;
    logic           cmvn_grant_q;
    logic           relu_grant_q;
    logic           src_sel_q;

    // Per stage: [2]=en, [1]=clr, [0]=last.
    logic [RD_LAT-1:0][2:0] pipe_q;
    logic [2:0]             pipe_d;

    logic pick_vld;
    logic pick_src;
    logic arb_upd;

    assign arb_upd = (state_q == ST_DONE);

    linear_rr_arb u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmvn_req (cmvn_req),
        .relu_req (relu_req),
        .upd      (arb_upd),
        .upd_src  (src_sel_q),
        .pick_vld (pick_vld),
        .pick_src (pick_src)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            o_q          <= '0;
            w_q          <= '0;
            drain_q      <= '0;
            in_rd_en_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            cmvn_grant_q <= 1'b0;
            relu_grant_q <= 1'b0;
            src_sel_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q      <= ST_ISSUE;
                        src_sel_q    <= pick_src;
                        cmvn_grant_q <= ~pick_src;
                        relu_grant_q <= pick_src;
                        in_rd_en_q   <= 1'b1;
                        i_q          <= '0;
                        o_q          <= '0;
                        w_q          <= '0;
                    end
                end
                ST_ISSUE: begin
                    if (i_q == I_LAST) begin
                        in_rd_en_q <= 1'b0;
                        drain_q    <= '0;
                        state_q    <= ST_DRAIN;
                    end else begin
                        i_q <= i_q + 1'b1;
                        w_q <= w_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // drain_q counts cycles since the delayed last strobe reached the MAC.
                    if (drain_q != '0) begin
                        if (drain_q == D_LAST) begin
                            drain_q     <= '0;
                            res_valid_q <= 1'b1;
                            state_q     <= ST_EMIT;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end else if (pipe_q[RD_LAT-1][0]) begin
                        drain_q <= DW'(1);
                    end
                end
                ST_EMIT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        i_q         <= '0;
                        if (o_q == O_LAST) begin
                            o_q          <= '0;
                            w_q          <= '0;
                            done_q       <= 1'b1;
                            cmvn_grant_q <= 1'b0;
                            relu_grant_q <= 1'b0;
                            state_q      <= ST_DONE;
                        end else begin
                            // Row base advances by one past the previous row's last weight.
                            o_q        <= o_q + 1'b1;
                            w_q        <= w_q + 1'b1;
                            in_rd_en_q <= 1'b1;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pipe_d = {in_rd_en_q,
                     in_rd_en_q && (i_q == '0),
                     in_rd_en_q && (i_q == I_LAST)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= pipe_d;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_q[s] <= pipe_q[s-1];
            end
        end
    end

    assign cmvn_grant = cmvn_grant_q;
    assign relu_grant = relu_grant_q;
    assign src_sel    = src_sel_q;
    assign in_rd_en   = in_rd_en_q;
    assign in_rd_addr = i_q;
    assign w_rd_addr  = w_q;
    assign mac_en     = pipe_q[RD_LAT-1][2];
    assign mac_clr    = pipe_q[RD_LAT-1][1];
    assign mac_last   = pipe_q[RD_LAT-1][0];
    assign res_valid  = res_valid_q;
    assign res_addr   = o_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_linear_sched.sv
// Directed bench for linear_sched at IN_DIM=OUT_DIM=20, RD_LAT=MAC_LAT=1 (row = 23 cycles).
module tb_linear_sched;

    logic       clk;
    logic       rst_n;
    logic       cmvn_req;
    logic       relu_req;
    logic       cmvn_grant;
    logic       relu_grant;
    logic       src_sel;
    logic       in_rd_en;
    logic [4:0] in_rd_addr;
    logic [8:0] w_rd_addr;
    logic       mac_clr;
    logic       mac_en;
    logic       mac_last;
    logic       res_valid;
    logic [4:0] res_addr;
    logic       res_ready;
    logic       busy;
    logic       done;

    int tests;
    int fails;

    linear_sched #(
        .IN_DIM  (20),
        .OUT_DIM (20),
        .RD_LAT  (1),
        .MAC_LAT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmvn_req   (cmvn_req),
        .relu_req   (relu_req),
        .cmvn_grant (cmvn_grant),
        .relu_grant (relu_grant),
        .src_sel    (src_sel),
        .in_rd_en   (in_rd_en),
        .in_rd_addr (in_rd_addr),
        .w_rd_addr  (w_rd_addr),
        .mac_clr    (mac_clr),
        .mac_en     (mac_en),
        .mac_last   (mac_last),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {3'b0, cmvn_grant, relu_grant, src_sel, in_rd_en, in_rd_addr, w_rd_addr,
                mac_clr, mac_en, mac_last, res_valid, res_addr, busy, done};
    endfunction

    // Entered on the first granted cycle; walks a reference row timeline
    // (issue p=0..19, MAC strobes p=1..20, result from p=22 until accepted).
    task automatic run_frame(input logic src, input int stall_row, input int stall_len,
                             input int drop_at, input int exp_len, input string tag);
        int row, p, k, stalled;
        int bad_rd, bad_addr, bad_mac, bad_res, bad_ctl;
        int n_acc, n_last, n_clr, n_w399, w_max, done_k, n_done;
        bit fin;
        row = 0; p = 0; k = 0; stalled = 0; fin = 0;
        bad_rd = 0; bad_addr = 0; bad_mac = 0; bad_res = 0; bad_ctl = 0;
        n_acc = 0; n_last = 0; n_clr = 0; n_w399 = 0; w_max = 0; done_k = -1; n_done = 0;
        while (!fin && k < 2000) begin
            if (k == drop_at) begin
                cmvn_req = 1'b0;
                relu_req = 1'b0;
            end
            if (in_rd_en !== (p < 20)) bad_rd++;
            if (p < 20 && (in_rd_addr !== 5'(p) || w_rd_addr !== 9'(row * 20 + p))) bad_addr++;
            if ({mac_en, mac_clr, mac_last} !== {(p >= 1 && p <= 20), (p == 1), (p == 20)}) bad_mac++;
            if (res_valid !== (p >= 22) || (p >= 22 && res_addr !== 5'(row))) bad_res++;
            if (cmvn_grant !== ~src || relu_grant !== src || src_sel !== src || busy !== 1'b1) bad_ctl++;
            if (done) begin n_done++; done_k = k; end
            if (mac_last) n_last++;
            if (mac_clr) n_clr++;
            if (in_rd_en && w_rd_addr == 9'd399) n_w399++;
            if (int'(w_rd_addr) > w_max) w_max = int'(w_rd_addr);
            if (row == stall_row && p >= 22 && stalled < stall_len) begin
                res_ready = 1'b0;
                stalled++;
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && res_ready) n_acc++;
            if (p >= 22 && res_ready) begin
                if (row == 19) fin = 1'b1;
                else begin row++; p = 0; end
            end else begin
                p++;
            end
            k++;
            tick();
        end
        check({tag, "_no_timeout"}, 32'(fin), 32'd1);
        if (done) begin n_done++; done_k = k; end
        check({tag, "_grant_drop"}, {30'b0, cmvn_grant, relu_grant}, 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        tick();
        if (done) n_done++;
        check({tag, "_idle_after"}, {30'b0, busy, res_valid}, 32'd0);
        check({tag, "_rd_en"}, bad_rd, 0);
        check({tag, "_addr"}, bad_addr, 0);
        check({tag, "_mac_strobes"}, bad_mac, 0);
        check({tag, "_result"}, bad_res, 0);
        check({tag, "_grant_src"}, bad_ctl, 0);
        check({tag, "_rows_accepted"}, n_acc, 20);
        check({tag, "_mac_last_cnt"}, n_last, 20);
        check({tag, "_mac_clr_cnt"}, n_clr, 20);
        check({tag, "_w399_once"}, n_w399, 1);
        check({tag, "_w_max"}, w_max, 399);
        check({tag, "_done_cycle"}, done_k, exp_len);
        check({tag, "_done_once"}, n_done, 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        cmvn_req = 1'b0;
        relu_req = 1'b0;
        res_ready = 1'b1;
        tick();
        tick();

        check("reset_all_outputs", all_outs(), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_no_req", {30'b0, busy, cmvn_grant | relu_grant}, 32'd0);

        // CMVN alone.
        cmvn_req = 1'b1;
        tick();
        check("cmvn_first_grant", {29'b0, cmvn_grant, relu_grant, src_sel}, 32'b100);
        run_frame(1'b0, -1, 0, 0, 460, "cmvn_only");

        // Tie from reset: CMVN, then ReLU, then CMVN again.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmvn_req = 1'b1;
        relu_req = 1'b1;
        tick();
        run_frame(1'b0, -1, 0, -1, 460, "tie_cmvn");
        tick();
        run_frame(1'b1, -1, 0, -1, 460, "tie_relu");
        tick();
        run_frame(1'b0, -1, 0, 0, 460, "tie_cmvn2");

        // Downstream stall of 10 cycles on row 5.
        cmvn_req = 1'b1;
        tick();
        run_frame(1'b0, 5, 10, 0, 470, "stall_row5");

        // ReLU request dropped three cycles into its frame.
        relu_req = 1'b1;
        tick();
        run_frame(1'b1, -1, 0, 3, 460, "relu_drop");

        // Reset during ISSUE of row 7, then restart.
        cmvn_req = 1'b1;
        tick();
        cmvn_req = 1'b0;
        repeat (166) tick();
        check("row7_issue_en", 32'(in_rd_en), 32'd1);
        check("row7_issue_w", 32'(w_rd_addr), 32'd145);
        rst_n = 1'b0;
        #1;
        check("midframe_reset_outputs", all_outs(), 32'd0);
        tick();
        rst_n = 1'b1;
        cmvn_req = 1'b1;
        tick();
        check("restart_w_addr", 32'(w_rd_addr), 32'd0);
        check("restart_rd_en", {30'b0, in_rd_en, cmvn_grant}, 32'b11);
        run_frame(1'b0, -1, 0, 0, 460, "restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
